dest_scoreboard: RTL and testbench

- Consumer end of the register destination-address path.
- Receives the 5-bit write address chosen by the rt/rd destination select at issue, and tracks it through the EX, MEM and WB stages.
- Compares each newly issued instruction's source addresses against the in-flight destinations.
- Produces the forwarding selects for both ALU operands, plus a load-use stall implemented as a valid/ready handshake on the issue interface.

---
 rtl/dest_scoreboard.sv | 106 ++++++++++
 tb/tb_dest_scoreboard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dest_scoreboard.sv
// Tracks issued register destinations through EX/MEM/WB; drives operand forwarding selects and a one-cycle load-use stall.
// Combinational fwd/stall from registered entries; issue_ready drops (no accept) only on a load-use hazard, and the source holds.
module dest_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic              issue_we,
   input  logic              issue_is_load,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic              src_a_used,
   input  logic              src_b_used,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_dest,
   output logic [CNT_W-1:0]  stall_count
);

   logic              r_ex_v, r_mem_v, r_wb_v;
   logic [ADDR_W-1:0] r_ex_dest, r_mem_dest, r_wb_dest;
   logic              r_ex_ld;
   logic [CNT_W-1:0]  r_cnt;

   logic w_ex_live, w_mem_live, w_wb_live;
   logic w_a_ex, w_a_mem, w_a_wb;
   logic w_b_ex, w_b_mem, w_b_wb;
   logic w_stall;

   // r0 is hardwired zero, so an entry writing it never forwards.
   assign w_ex_live  = r_ex_v  & (r_ex_dest  != '0);
   assign w_mem_live = r_mem_v & (r_mem_dest != '0);
   assign w_wb_live  = r_wb_v  & (r_wb_dest  != '0);

   assign w_a_ex  = src_a_used & w_ex_live  & (r_ex_dest  == src_a);
   assign w_a_mem = src_a_used & w_mem_live & (r_mem_dest == src_a);
   assign w_a_wb  = src_a_used & w_wb_live  & (r_wb_dest  == src_a);
   assign w_b_ex  = src_b_used & w_ex_live  & (r_ex_dest  == src_b);
   assign w_b_mem = src_b_used & w_mem_live & (r_mem_dest == src_b);
   assign w_b_wb  = src_b_used & w_wb_live  & (r_wb_dest  == src_b);

   always_comb begin
      fwd_a = 2'b00;
      if (w_a_ex)       fwd_a = 2'b01;
      else if (w_a_mem) fwd_a = 2'b10;
      else if (w_a_wb)  fwd_a = 2'b11;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (w_b_ex)       fwd_b = 2'b01;
      else if (w_b_mem) fwd_b = 2'b10;
      else if (w_b_wb)  fwd_b = 2'b11;
   end

   // Load data only exists at the end of MEM, so only an EX-stage load can stall.
   assign w_stall     = issue_valid & r_ex_ld & (w_a_ex | w_b_ex) & ~flush;
   assign stall       = w_stall;
   assign issue_ready = ~w_stall;

   assign wb_valid    = w_wb_live;
   assign wb_dest     = r_wb_dest;
   assign stall_count = r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_v     <= 1'b0;
         r_mem_v    <= 1'b0;
         r_wb_v     <= 1'b0;
         r_ex_ld    <= 1'b0;
         r_ex_dest  <= '0;
         r_mem_dest <= '0;
         r_wb_dest  <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_stall && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
         // The MEM entry is older than the redirect, so it still retires through WB.
         r_wb_v    <= r_mem_v;
         r_wb_dest <= r_mem_dest;
         if (flush) begin
            r_ex_v  <= 1'b0;
            r_mem_v <= 1'b0;
         end else begin
            r_mem_v    <= r_ex_v;
            r_mem_dest <= r_ex_dest;
            if (w_stall) begin
               r_ex_v  <= 1'b0;
               r_ex_ld <= 1'b0;
            end else begin
               r_ex_v    <= issue_valid & issue_we;
               r_ex_dest <= issue_dest;
               r_ex_ld   <= issue_is_load;
            end
         end
      end
   end

endmodule

// File: tb/tb_dest_scoreboard.sv
// Bench for dest_scoreboard: directed vector table, stall-counter saturation/reset sequences, then random traffic vs a model.
module tb_dest_scoreboard;

   logic       clk;
   logic       reset, flush, issue_valid, issue_we, issue_is_load;
   logic [4:0] issue_dest, src_a, src_b;
   logic       src_a_used, src_b_used;

   logic        issue_ready, stall, wb_valid;
   logic [1:0]  fwd_a, fwd_b;
   logic [4:0]  wb_dest;
   logic [15:0] stall_count;

   logic        u2_ready, u2_stall, u2_wbv;
   logic [1:0]  u2_fa, u2_fb;
   logic [4:0]  u2_wbd;
   logic [1:0]  u2_cnt;

   int n_chk = 0;
   int n_err = 0;

   dest_scoreboard u_dut (
      .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
      .issue_ready(issue_ready), .issue_we(issue_we), .issue_is_load(issue_is_load),
      .issue_dest(issue_dest), .src_a(src_a), .src_b(src_b),
      .src_a_used(src_a_used), .src_b_used(src_b_used),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .wb_valid(wb_valid),
      .wb_dest(wb_dest), .stall_count(stall_count)
   );

   dest_scoreboard #(.ADDR_W(5), .CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
      .issue_ready(u2_ready), .issue_we(issue_we), .issue_is_load(issue_is_load),
      .issue_dest(issue_dest), .src_a(src_a), .src_b(src_b),
      .src_a_used(src_a_used), .src_b_used(src_b_used),
      .fwd_a(u2_fa), .fwd_b(u2_fb), .stall(u2_stall), .wb_valid(u2_wbv),
      .wb_dest(u2_wbd), .stall_count(u2_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: list of in-flight instructions, index 0 = youngest.
   typedef struct {
      bit       v;
      bit [4:0] d;
      bit       ld;
   } ent_t;

   ent_t        pipe [3];
   int unsigned m_cnt16 = 0;
   int unsigned m_cnt2  = 0;

   function automatic logic [1:0] m_fwd(logic [4:0] s, logic used);
      for (int i = 0; i < 3; i++)
         if (used && pipe[i].v && pipe[i].d != 0 && pipe[i].d == s)
            return 2'(i + 1);
      return 2'd0;
   endfunction

   function automatic bit m_stall();
      bit hit;
      hit = (src_a_used && src_a == pipe[0].d) || (src_b_used && src_b == pipe[0].d);
      return issue_valid && !flush && pipe[0].v && pipe[0].ld && pipe[0].d != 0 && hit;
   endfunction

   always @(posedge clk) begin
      bit st;
      st = m_stall();
      if (reset) begin
         for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
         m_cnt16 = 0;
         m_cnt2  = 0;
      end else begin
         if (st) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         pipe[2] = pipe[1];
         if (flush) begin
            pipe[1].v = 1'b0;
            pipe[0].v = 1'b0;
         end else begin
            pipe[1] = pipe[0];
            if (st) pipe[0] = '{1'b0, 5'd0, 1'b0};
            else    pipe[0] = '{issue_valid && issue_we, issue_dest, issue_is_load};
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(bit fl, bit iv, bit we, bit ld, logic [4:0] dst,
                         logic [4:0] sa, bit ua, logic [4:0] sb, bit ub);
      flush = fl; issue_valid = iv; issue_we = we; issue_is_load = ld;
      issue_dest = dst; src_a = sa; src_a_used = ua; src_b = sb; src_b_used = ub;
   endtask

   typedef struct {
      bit         fl, iv, we, ld;
      logic [4:0] dst, sa;
      bit         ua;
      logic [4:0] sb;
      bit         ub;
      logic [1:0] fa, fb;
      bit         st, wbv;
      logic [4:0] wbd;
      int         cnt;
   } vec_t;

   vec_t tbl[$];

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

      //          fl iv we ld dst sa ua sb ub   fa fb st wbv wbd cnt
      tbl.push_back('{0, 1, 1, 0,  5,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0});
      tbl.push_back('{0, 1, 1, 0,  9,  5, 1,  5, 1,  1, 1, 0, 0,  0, 0});
      tbl.push_back('{0, 1, 0, 0,  0,  5, 1,  5, 1,  2, 2, 0, 0,  0, 0});
      tbl.push_back('{0, 1, 0, 0,  0,  5, 1,  9, 1,  3, 2, 0, 1,  5, 0});
      tbl.push_back('{0, 0, 0, 0,  0,  5, 1,  9, 1,  0, 3, 0, 1,  9, 0});
      tbl.push_back('{0, 1, 1, 1,  8,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0});
      tbl.push_back('{0, 1, 1, 0, 10,  1, 1,  8, 1,  0, 1, 1, 0,  0, 0});
      tbl.push_back('{0, 1, 1, 0, 10,  1, 1,  8, 1,  0, 2, 0, 0,  0, 1});
      tbl.push_back('{0, 0, 0, 0,  0,  8, 1, 10, 1,  3, 1, 0, 1,  8, 1});
      tbl.push_back('{0, 1, 1, 0,  0,  0, 1, 10, 1,  0, 2, 0, 0,  0, 1});
      tbl.push_back('{0, 1, 1, 1,  3,  0, 1,  0, 1,  0, 0, 0, 1, 10, 1});
      tbl.push_back('{0, 1, 0, 0,  0,  3, 0,  3, 0,  0, 0, 0, 0,  0, 1});
      tbl.push_back('{0, 0, 0, 0,  0,  0, 1,  0, 1,  0, 0, 0, 0,  0, 1});
      tbl.push_back('{0, 0, 0, 0,  0,  3, 1,  0, 0,  3, 0, 0, 1,  3, 1});
      tbl.push_back('{0, 1, 1, 0,  4,  0, 0,  0, 0,  0, 0, 0, 0,  0, 1});
      tbl.push_back('{0, 1, 1, 0,  4,  4, 1,  0, 0,  1, 0, 0, 0,  0, 1});
      tbl.push_back('{0, 1, 1, 0,  4,  4, 1,  4, 1,  1, 1, 0, 0,  0, 1});
      tbl.push_back('{0, 1, 0, 0,  0,  4, 1,  4, 1,  1, 1, 0, 1,  4, 1});
      tbl.push_back('{0, 0, 0, 0,  0,  4, 1,  0, 0,  2, 0, 0, 1,  4, 1});
      tbl.push_back('{0, 1, 1, 0,  4,  0, 0,  0, 0,  0, 0, 0, 1,  4, 1});
      tbl.push_back('{0, 1, 1, 0,  4,  4, 1,  0, 0,  1, 0, 0, 0,  0, 1});
      tbl.push_back('{1, 1, 1, 0,  4,  4, 1,  0, 0,  1, 0, 0, 0,  0, 1});
      tbl.push_back('{0, 0, 0, 0,  0,  4, 1,  4, 1,  3, 3, 0, 1,  4, 1});
      tbl.push_back('{0, 1, 1, 1,  7,  0, 0,  0, 0,  0, 0, 0, 0,  0, 1});
      tbl.push_back('{1, 1, 1, 0, 11,  7, 1,  0, 0,  1, 0, 0, 0,  0, 1});
      tbl.push_back('{0, 0, 0, 0,  0,  7, 1,  0, 0,  0, 0, 0, 0,  0, 1});

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset ready", issue_ready, 1);
      chk("reset stall", stall, 0);
      chk("reset fwd_a", fwd_a, 0);
      chk("reset fwd_b", fwd_b, 0);
      chk("reset wb_valid", wb_valid, 0);
      chk("reset count16", stall_count, 0);
      chk("reset count2", u2_cnt, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         set_in(tbl[i].fl, tbl[i].iv, tbl[i].we, tbl[i].ld, tbl[i].dst,
                tbl[i].sa, tbl[i].ua, tbl[i].sb, tbl[i].ub);
         #1;
         chk($sformatf("row%0d fwd_a", i), fwd_a, tbl[i].fa);
         chk($sformatf("row%0d fwd_b", i), fwd_b, tbl[i].fb);
         chk($sformatf("row%0d stall", i), stall, tbl[i].st);
         chk($sformatf("row%0d ready", i), issue_ready, !tbl[i].st);
         chk($sformatf("row%0d wb_valid", i), wb_valid, tbl[i].wbv);
         if (tbl[i].wbv) chk($sformatf("row%0d wb_dest", i), wb_dest, tbl[i].wbd);
         chk($sformatf("row%0d count", i), stall_count, tbl[i].cnt);
      end

      // Five separate load-use events: the 2-bit counter pins at 3.
      for (int e = 1; e <= 5; e++) begin
         @(negedge clk); set_in(0, 1, 1, 1, 8, 0, 0, 0, 0);
         @(negedge clk); set_in(0, 1, 1, 0, 12, 0, 0, 8, 1);
         #1;
         chk($sformatf("sat%0d stall", e), stall, 1);
         @(negedge clk); #1;
         chk($sformatf("sat%0d stall released", e), stall, 0);
         chk($sformatf("sat%0d fwd_b", e), fwd_b, 2);
         chk($sformatf("sat%0d count16", e), stall_count, 1 + e);
         chk($sformatf("sat%0d count2", e), u2_cnt, (1 + e > 3) ? 3 : 1 + e);
      end

      // Reset while a hazard is being presented.
      @(negedge clk); set_in(0, 1, 1, 1, 8, 0, 0, 0, 0);
      @(negedge clk); set_in(0, 1, 1, 0, 12, 8, 1, 8, 1);
      reset = 1'b1;
      #1;
      chk("midreset stall", stall, 1);
      @(negedge clk); reset = 1'b0;
      #1;
      chk("postreset stall", stall, 0);
      chk("postreset fwd_a", fwd_a, 0);
      chk("postreset fwd_b", fwd_b, 0);
      chk("postreset wb_valid", wb_valid, 0);
      chk("postreset count16", stall_count, 0);
      chk("postreset count2", u2_cnt, 0);
      @(negedge clk); set_in(0, 0, 0, 0, 0, 8, 1, 12, 1);
      #1;
      chk("postreset2 wb_valid", wb_valid, 0);
      chk("postreset2 fwd_b", fwd_b, 1);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         bit exp_st, exp_wbv;
         @(negedge clk);
         reset = ($urandom_range(0, 99) == 0);
         set_in($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0);
         #1;
         exp_st  = m_stall();
         exp_wbv = pipe[2].v && pipe[2].d != 0;
         chk($sformatf("rnd%0d fwd_a", c), fwd_a, m_fwd(src_a, src_a_used));
         chk($sformatf("rnd%0d fwd_b", c), fwd_b, m_fwd(src_b, src_b_used));
         chk($sformatf("rnd%0d stall", c), stall, exp_st);
         chk($sformatf("rnd%0d ready", c), issue_ready, !exp_st);
         chk($sformatf("rnd%0d wb_valid", c), wb_valid, exp_wbv);
         if (exp_wbv) chk($sformatf("rnd%0d wb_dest", c), wb_dest, pipe[2].d);
         chk($sformatf("rnd%0d count16", c), stall_count, m_cnt16);
         chk($sformatf("rnd%0d count2", c), u2_cnt, m_cnt2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
